instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL provide one clock and an asynchronous, active-high reset: `clk` input 1, rising-edge clock; `reset` input 1, asynchronous active-high reset.
REQ-002 SHALL have port `in_valid` input 1: request fields valid.
REQ-003 SHALL have port `in_ready` output 1: block accepts request this cycle.
REQ-004 SHALL have port `fmt` input 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6-7=illegal.
REQ-005 SHALL have ports `opcode` input 7, `funct3` input 3 and `funct7` input 7: raw fields.
REQ-006 SHALL have ports `rd`, `rs1` and `rs2`, each input 5: register indices.
REQ-007 SHALL have port `imm` input 32: signed byte-offset or immediate value.
REQ-008 SHALL have ports `base_load` input 1 and `base_addr` input 32: load the address counter.
REQ-009 SHALL have ports `out_valid` output 1, `out_ready` input 1, `out_instr` output 32 and `out_addr` output 32: encoded word plus its instruction-memory address.
REQ-010 SHALL have ports `err` output 1 (sticky encode error) and `err_clr` input 1.
REQ-011 SHALL have port `word_cnt` output 16: count of words emitted, saturating.

Function
REQ-012 SHALL accept a request on `in_valid && in_ready`, with `in_ready = !out_valid || out_ready`, giving full throughput.
REQ-013 SHALL register the result, with latency one cycle from accept to `out_valid`.
REQ-014 SHALL hold `out_instr` and `out_addr` stable while `out_valid && !out_ready`.
REQ-015 SHALL pack R as `funct7|rs2|rs1|funct3|rd|opcode`.
REQ-016 SHALL pack I as `imm[11:0]|rs1|funct3|rd|opcode`.
REQ-017 SHALL pack S as `imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode`.
REQ-018 SHALL pack B as `imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode`.
REQ-019 SHALL pack U as `imm[31:12]|rd|opcode`.
REQ-020 SHALL pack J as `imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode`.
REQ-021 SHALL enforce these legal immediate ranges: I/S signed 12-bit (-2048..2047); B signed 13-bit, even; J signed 21-bit, even; U `imm[11:0]==0`; R ignores `imm`.
REQ-022 SHALL handle an illegal request (range violation or `fmt` 6-7) as follows: request is accepted and consumed, no word emitted, `out_valid` is not asserted for it, the address counter is unchanged, and `err` is set on the next edge.
REQ-023 SHALL advance the address counter by 4 per emitted word, set at accept time, with `out_addr` equal to the counter value before the increment; wraps 0xFFFFFFFC -> 0x00000000.
REQ-024 SHALL load the counter from `base_addr` on `base_load` with priority over the increment; an accept in the same cycle uses `base_addr` as its `out_addr` and the counter becomes `base_addr+4`.
REQ-025 SHALL increment `word_cnt` per emitted word (on the output handshake) and saturate at 0xFFFF.
REQ-026 SHALL clear `err` on `err_clr`; if a new error arrives in the same cycle, set wins.
REQ-027 SHALL use a state machine EMPTY/FULL of the output register: EMPTY->FULL on legal accept; FULL->EMPTY on `out_ready` with no legal accept; FULL->FULL on `out_ready` with legal accept.

Reset
REQ-028 SHALL, on `reset` asserted at any time: `out_valid`=0, `out_instr`=0, `out_addr`=0, counter=0, `err`=0, `word_cnt`=0, state EMPTY, with `in_ready`=1 after release.
REQ-029 SHALL discard a word pending on the output at reset and not emit it afterwards.

Verification
REQ-030 SHALL be checked with: fmt=I, op=0x13, rd=1, rs1=0, f3=0, imm=5 -> `out_instr`=0x00500093, `out_addr`=0x0 one cycle later.
REQ-031 SHALL be checked with: fmt=B, op=0x63, rs1=1, rs2=2, f3=0, imm=8 then fmt=J, op=0x6F, rd=1, imm=16 -> 0x00208463 @0x0, 0x010000EF @0x4.
REQ-032 SHALL be checked with: fmt=S, op=0x23, rs1=1, rs2=2, f3=2, imm=-4 -> 0xFE20AE23.
REQ-033 SHALL be checked with: fmt=I, imm=2048 -> no `out_valid`, `err`=1, next legal word at the unchanged address; `err_clr` -> `err`=0.
REQ-034 SHALL be checked with: `out_ready`=0 for 5 cycles with a word pending -> `in_ready`=0 and outputs held; release -> one handshake, `word_cnt` +1.
REQ-035 SHALL be checked with: `base_load`=1, `base_addr`=0xFFFFFFFC, two legal words -> addresses 0xFFFFFFFC, 0x00000000; reset with a word pending -> `out_valid`=0 and `word_cnt`=0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32 instruction fields into a 32-bit word. Each word
// is tagged with an auto-incrementing instruction-memory address and held in a
// one-deep output register with a valid/ready handshake.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  // request side
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  // address counter load
  input  logic        base_load,
  input  logic [31:0] base_addr,
  // result side
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  // status
  output logic        err,
  input  logic        err_clr,
  output logic [15:0] word_cnt
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  localparam logic [XLEN-1:0]  ADDR_STEP = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   instr_q;
  logic [XLEN-1:0]   oaddr_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   addr_d;
  logic              err_q;
  logic              err_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic              imm_s12_c;
  logic              imm_s13_c;
  logic              imm_s21_c;
  logic              imm_even_c;
  logic              imm_lo_zero_c;
  logic              legal_c;
  logic [XLEN-1:0]   instr_c;
  logic              accept_c;
  logic              emit_c;
  logic              handshake_c;
  logic [XLEN-1:0]   slot_addr_c;

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign out_instr = instr_q;
  assign out_addr  = oaddr_q;
  assign err       = err_q;
  assign word_cnt  = cnt_q;

  // Immediate range checks: a value fits N signed bits when every bit above
  // bit N-1 equals the sign bit.
  always_comb begin
    imm_s12_c     = (&imm[31:11]) || !(|imm[31:11]);
    imm_s13_c     = (&imm[31:12]) || !(|imm[31:12]);
    imm_s21_c     = (&imm[31:20]) || !(|imm[31:20]);
    imm_even_c    = !imm[0];
    imm_lo_zero_c = !(|imm[11:0]);
  end

  // Field packing and legality for the selected format.
  always_comb begin
    instr_c = '0;
    legal_c = 1'b0;
    case (fmt)
      FMT_R: begin
        instr_c = {funct7, rs2, rs1, funct3, rd, opcode};
        legal_c = 1'b1;
      end
      FMT_I: begin
        instr_c = {imm[11:0], rs1, funct3, rd, opcode};
        legal_c = imm_s12_c;
      end
      FMT_S: begin
        instr_c = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        legal_c = imm_s12_c;
      end
      FMT_B: begin
        instr_c = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        legal_c = imm_s13_c && imm_even_c;
      end
      FMT_U: begin
        instr_c = {imm[31:12], rd, opcode};
        legal_c = imm_lo_zero_c;
      end
      FMT_J: begin
        instr_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        legal_c = imm_s21_c && imm_even_c;
      end
      default: begin
        instr_c = '0;
        legal_c = 1'b0;
      end
    endcase
  end

  // Handshake qualifiers; a base load overrides the counter for this accept.
  always_comb begin
    accept_c    = in_valid && in_ready;
    emit_c      = accept_c && legal_c;
    handshake_c = out_valid && out_ready;
    slot_addr_c = base_load ? base_addr : addr_q;
  end

  // Next values for the address counter, sticky error and word counter.
  always_comb begin
    addr_d = addr_q;
    err_d  = err_q;
    cnt_d  = cnt_q;

    if (emit_c) begin
      addr_d = slot_addr_c + ADDR_STEP;
    end else if (base_load) begin
      addr_d = base_addr;
    end

    if (accept_c && !legal_c) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end

    if (handshake_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  // Output-register occupancy FSM; reset drops any pending word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      instr_q <= '0;
      oaddr_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (emit_c) begin
            state_q <= ST_FULL;
            instr_q <= instr_c;
            oaddr_q <= slot_addr_c;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (emit_c) begin
              state_q <= ST_FULL;
              instr_q <= instr_c;
              oaddr_q <= slot_addr_c;
            end else begin
              state_q <= ST_EMPTY;
            end
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors plus random traffic
// checked against an arithmetic reference encoder.
module tb_instr_encoder;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        base_load;
  logic [31:0] base_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic        err_clr;
  logic [15:0] word_cnt;

  instr_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .base_load (base_load),
    .base_addr (base_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .err_clr   (err_clr),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_fail;
  exp_t        sb_q[$];
  logic [31:0] m_addr;
  logic        exp_err;
  int          exp_cnt;

  // DUT outputs sampled by the driver on the falling edge of each step
  logic        s_valid;
  logic        s_inready;
  logic        s_err;
  logic [31:0] s_instr;
  logic [31:0] s_addr;
  logic [15:0] s_wcnt;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic req_t mk(input int f, input int op, input int f3, input int f7,
                              input int rdv, input int r1, input int r2, input logic [31:0] iv);
    req_t r;
    r.fmt = 3'(f);
    r.op  = 7'(op);
    r.f3  = 3'(f3);
    r.f7  = 7'(f7);
    r.rd  = 5'(rdv);
    r.rs1 = 5'(r1);
    r.rs2 = 5'(r2);
    r.imm = iv;
    return r;
  endfunction

  // Reference encoder: places each field by weight (field value times the
  // power of two of its lowest bit) and checks ranges on the signed integer.
  function automatic bit ref_encode(input req_t r, output logic [31:0] w);
    logic [31:0] u, op, rdw, f3w, r1w, r2w, f7w;
    int s;
    u   = r.imm;
    s   = $signed(r.imm);
    op  = 32'(r.op);
    rdw = 32'h0000_0080;
    f3w = 32'h0000_1000;
    r1w = 32'h0000_8000;
    r2w = 32'h0010_0000;
    f7w = 32'h0200_0000;
    case (r.fmt)
      3'd0: begin
        w = op + 32'(r.rd) * rdw + 32'(r.f3) * f3w + 32'(r.rs1) * r1w
               + 32'(r.rs2) * r2w + 32'(r.f7) * f7w;
        return 1'b1;
      end
      3'd1: begin
        w = op + 32'(r.rd) * rdw + 32'(r.f3) * f3w + 32'(r.rs1) * r1w + (u % 4096) * r2w;
        return (s >= -2048) && (s <= 2047);
      end
      3'd2: begin
        w = op + (u % 32) * rdw + 32'(r.f3) * f3w + 32'(r.rs1) * r1w
               + 32'(r.rs2) * r2w + ((u / 32) % 128) * f7w;
        return (s >= -2048) && (s <= 2047);
      end
      3'd3: begin
        w = op + (((u / 2) % 16) * 2 + (u / 2048) % 2) * rdw + 32'(r.f3) * f3w
               + 32'(r.rs1) * r1w + 32'(r.rs2) * r2w
               + ((u / 32) % 64 + ((u / 4096) % 2) * 64) * f7w;
        return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
      end
      3'd4: begin
        w = op + 32'(r.rd) * rdw + (u / 4096) * 4096;
        return (u % 4096) == 0;
      end
      3'd5: begin
        w = op + 32'(r.rd) * rdw + ((u / 4096) % 256) * f3w
               + ((u / 2048) % 2) * r2w + ((u / 2) % 1024) * 32'h0020_0000
               + ((u / 32'h0010_0000) % 2) * 32'h8000_0000;
        return (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
      end
      default: begin
        w = 32'h0;
        return 1'b0;
      end
    endcase
  endfunction

  // One clock of stimulus; entered and left just after a rising edge.
  task automatic step(input bit v, input req_t r, input bit ordy,
                      input bit bl, input logic [31:0] ba, input bit eclr);
    logic [31:0] w;
    logic [31:0] slot;
    bit lg, exp_rdy, acc;
    in_valid  = v;
    fmt       = r.fmt;
    opcode    = r.op;
    funct3    = r.f3;
    funct7    = r.f7;
    rd        = r.rd;
    rs1       = r.rs1;
    rs2       = r.rs2;
    imm       = r.imm;
    out_ready = ordy;
    base_load = bl;
    base_addr = ba;
    err_clr   = eclr;
    @(negedge clk);
    #1;
    s_valid   = out_valid;
    s_inready = in_ready;
    s_err     = err;
    s_instr   = out_instr;
    s_addr    = out_addr;
    s_wcnt    = word_cnt;
    exp_rdy   = ordy || (sb_q.size() == 0);
    cmp("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc  = v && exp_rdy;
    lg   = ref_encode(r, w);
    slot = bl ? ba : m_addr;
    if (acc && lg) begin
      sb_q.push_back('{instr: w, addr: slot});
      m_addr = slot + 32'd4;
    end else if (bl) begin
      m_addr = ba;
    end
    if (acc && !lg) exp_err = 1'b1;
    else if (eclr) exp_err = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, '0, ordy, 1'b0, 32'h0, 1'b0);
  endtask

  function automatic req_t rand_req();
    req_t r;
    int bnd[10] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098, 1048574, -1048576};
    r.fmt = 3'($urandom_range(0, 7));
    r.op  = 7'($urandom);
    r.f3  = 3'($urandom);
    r.f7  = 7'($urandom);
    r.rd  = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    case ($urandom_range(0, 3))
      0: r.imm = $urandom;
      1: r.imm = 32'(bnd[$urandom_range(0, 9)]);
      default: begin
        case (r.fmt)
          3'd3:    r.imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
          3'd4:    r.imm = $urandom & 32'hFFFF_F000;
          3'd5:    r.imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
          default: r.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
        endcase
      end
    endcase
    return r;
  endfunction

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      exp_cnt = 0;
      cmp("reset out_valid", 32'(out_valid), 32'h0);
      cmp("reset word_cnt", 32'(word_cnt), 32'h0);
    end else begin
      cmp("word_cnt", 32'(word_cnt), 32'(exp_cnt));
      cmp("err", 32'(err), 32'(exp_err));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected word: got %h @%h expected none", out_instr, out_addr);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          cmp("out_instr", out_instr, e.instr);
          cmp("out_addr", out_addr, e.addr);
        end
        exp_cnt = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
      end
    end
  end

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    m_addr    = 32'h0;
    exp_err   = 1'b0;
    exp_cnt   = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    fmt       = 3'd0;
    opcode    = 7'd0;
    funct3    = 3'd0;
    funct7    = 7'd0;
    rd        = 5'd0;
    rs1       = 5'd0;
    rs2       = 5'd0;
    imm       = 32'h0;
    base_load = 1'b0;
    base_addr = 32'h0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst out_valid", 32'(out_valid), 32'h0);
    cmp("rst out_instr", out_instr, 32'h0);
    cmp("rst out_addr", out_addr, 32'h0);
    cmp("rst err", 32'(err), 32'h0);
    cmp("rst word_cnt", 32'(word_cnt), 32'h0);
    reset = 1'b0;
    idle(1'b1);
    cmp("post-reset in_ready", 32'(s_inready), 32'h1);

    // addi x1, x0, 5
    step(1'b1, mk(1, 'h13, 0, 0, 1, 0, 0, 32'd5), 1'b1, 1'b0, 32'h0, 1'b0);
    idle(1'b1);
    cmp("addi valid", 32'(s_valid), 32'h1);
    cmp("addi instr", s_instr, 32'h0050_0093);
    cmp("addi addr", s_addr, 32'h0);

    // beq then jal, counter reloaded to 0
    step(1'b1, mk(3, 'h63, 0, 0, 0, 1, 2, 32'd8), 1'b1, 1'b1, 32'h0, 1'b0);
    step(1'b1, mk(5, 'h6F, 0, 0, 1, 0, 0, 32'd16), 1'b1, 1'b0, 32'h0, 1'b0);
    cmp("beq instr", s_instr, 32'h0020_8463);
    cmp("beq addr", s_addr, 32'h0);
    idle(1'b1);
    cmp("jal instr", s_instr, 32'h0100_00EF);
    cmp("jal addr", s_addr, 32'h4);

    // sw x2, -4(x1)
    step(1'b1, mk(2, 'h23, 2, 0, 0, 1, 2, 32'hFFFF_FFFC), 1'b1, 1'b0, 32'h0, 1'b0);
    idle(1'b1);
    cmp("sw instr", s_instr, 32'hFE20_AE23);

    // out-of-range I immediate: consumed, no word, err set, address kept
    step(1'b1, mk(1, 'h13, 0, 0, 1, 0, 0, 32'd2048), 1'b1, 1'b1, 32'h100, 1'b0);
    idle(1'b1);
    cmp("illegal no valid", 32'(s_valid), 32'h0);
    cmp("illegal err", 32'(s_err), 32'h1);
    step(1'b1, mk(1, 'h13, 0, 0, 1, 0, 0, 32'd5), 1'b1, 1'b0, 32'h0, 1'b0);
    idle(1'b1);
    cmp("after illegal addr", s_addr, 32'h100);
    step(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b1);
    idle(1'b1);
    cmp("err cleared", 32'(s_err), 32'h0);

    // backpressure: sub x1,x2,x3 held for 5 cycles
    step(1'b1, mk(0, 'h33, 0, 'h20, 1, 2, 3, 32'h0), 1'b0, 1'b1, 32'h200, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, mk(0, 'h33, 7, 0, 4, 5, 6, 32'h0), 1'b0, 1'b0, 32'h0, 1'b0);
      cmp("stall in_ready", 32'(s_inready), 32'h0);
      cmp("stall instr", s_instr, 32'h4031_00B3);
      cmp("stall addr", s_addr, 32'h200);
    end
    cmp("stall word_cnt", 32'(s_wcnt), 32'd5);
    idle(1'b1);
    idle(1'b1);
    cmp("release word_cnt", 32'(s_wcnt), 32'd6);

    // address wrap
    step(1'b1, mk(1, 'h13, 0, 0, 1, 0, 0, 32'd1), 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b1, mk(1, 'h13, 0, 0, 2, 0, 0, 32'd2), 1'b1, 1'b0, 32'h0, 1'b0);
    cmp("wrap addr0", s_addr, 32'hFFFF_FFFC);
    idle(1'b1);
    cmp("wrap addr1", s_addr, 32'h0);

    // reset with a word pending
    step(1'b1, mk(1, 'h13, 0, 0, 3, 0, 0, 32'd3), 1'b0, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    cmp("pending valid", 32'(s_valid), 32'h1);
    reset   = 1'b1;
    sb_q.delete();
    m_addr  = 32'h0;
    exp_err = 1'b0;
    @(negedge clk);
    #1;
    cmp("reset drop valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1'b1);
    cmp("dropped valid", 32'(s_valid), 32'h0);
    cmp("dropped in_ready", 32'(s_inready), 32'h1);
    cmp("dropped word_cnt", 32'(s_wcnt), 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 5) != 0, rand_req(), ($urandom % 4) != 0,
           ($urandom % 20) == 0, $urandom & 32'hFFFF_FFFC, ($urandom % 10) == 0);
    end
    repeat (3) idle(1'b1);
    cmp("scoreboard drained", 32'(sb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
